lane_loader: RTL
================

# lane_loader

Upstream write sequencer for the open-lane memory bank. It accepts a stream of words on a valid/ready handshake and writes them into consecutive lanes, starting at lane 0, one write per accepted word. It tracks which lanes hold fresh data and exposes a full flag. It stalls the stream until the downstream consumer releases the bank. Its write outputs connect directly to the bank's write port (write strobe, lane index, data).

## Interface
- NLANES, 4, number of lanes in the bank; 2 ≤ NLANES ≤ 2**LWIDTH
- LWIDTH, 2, lane index width
- DWIDTH, 8, data word width
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- i_valid  in  1  upstream word valid
- i_data  in  DWIDTH  upstream word
- o_ready  out  1  loader can accept a word this cycle
- i_release  in  1  downstream releases the bank: clears fill state (also aborts a partial fill)
- o_wr  out  1  bank write strobe, one-cycle pulse per accepted word
- o_wlane  out  LWIDTH  bank lane index for o_wr
- o_wdata  out  DWIDTH  bank write data for o_wr
- o_fill  out  NLANES  bit k set means lane k holds data written since the last release
- o_count  out  LWIDTH+1  number of lanes filled, 0..NLANES
- o_full  out  1  o_count == NLANES

## Operation
- **State machine**, three states:
  - IDLE: count 0.
  - FILL: 0 < count < NLANES.
  - FULL: count == NLANES.
- **Accept.** A word is accepted when i_valid && o_ready.
  - o_ready = (state != FULL) && !i_release. It is combinational in i_release only.
- **Per accepted word, next edge:**
  - o_wr=1, o_wlane=ptr, o_wdata=i_data.
  - o_fill[ptr] is set.
  - count increments.
  - ptr increments; it wraps from NLANES-1 to 0.
  - Transitions: IDLE→FILL, or FILL→FULL when count reaches NLANES. With NLANES accepts, IDLE→FILL→…→FULL.
- **No accept:** o_wr=0. o_wlane and o_wdata hold their last values.
- **i_release in any state, next edge:** count=0, ptr=0, o_fill=0, state=IDLE.
  - A release in FULL is the normal handoff.
  - A release in IDLE or FILL is an abort. Lanes already written keep their bank contents but are reported empty.
- **Simultaneous i_valid and i_release:** release wins. o_ready is low, so the word is not accepted and no o_wr is produced.
- **In FULL:** o_ready=0. i_valid is ignored and the upstream holds its word.
- **Arithmetic:** count and ptr are unsigned. ptr never exceeds NLANES-1. count never exceeds NLANES.
- **Reset** (rst low, async) sets all outputs:
  - o_wr=0, o_wlane=0, o_wdata=0, o_fill=0, o_count=0, o_full=0.
  - Internal: state=IDLE, ptr=0.
  - o_ready is 0 while rst is low and 1 from the first cycle after deassertion.
- **Reset mid-fill:** all progress is discarded. A pulse on o_wr already issued is not retracted; a pending one is cancelled.

## Timing
- Handshake to bank write: latency 1 cycle. o_wr, o_wlane and o_wdata are registered.
- o_fill, o_count and o_full update on the same edge as the corresponding o_wr.
- o_full rises together with the final o_wr, so the bank data for every set o_fill bit is valid from the following edge onward.
- Throughput: one word per cycle from IDLE through FILL. NLANES back-to-back accepts fill the bank in NLANES cycles.
- Release to ready: i_release sampled at edge t gives o_ready=1 in cycle t+1, provided i_release is low then. Minimum turnaround after the final accept is 1 cycle.
- Mandatory registered outputs: o_wr, o_wlane, o_wdata, o_fill, o_count, o_full. The only combinational path is i_release→o_ready.

## Structure
- **Shared package (project memory package):**
  - State encoding constants LL_IDLE=2'd0, LL_FILL=2'd1, LL_FULL=2'd2.
  - Default NLANES, LWIDTH and DWIDTH, so that the loader and the bank are instantiated from the same values.
- **Sub-module lane_ptr:** a natural split. It is a wrapping pointer/counter with inc, clear and wrap-at-NLANES, and is reusable by the read-side consumer.
- **Top level:** FSM, fill mask and output registers.
- **Size:** roughly 150–250 lines total.

## Test plan
- **Reset:** assert rst low mid-run with i_valid=1 → all outputs 0 and o_ready=0. After release of rst, o_ready=1 next cycle.
- **Streaming fill, NLANES=4:** i_valid=1 for 4 cycles with data 0x11,0x22,0x33,0x44.
  - o_wr pulses on 4 consecutive cycles, each one cycle after its accept.
  - o_wlane sequence is 0,1,2,3 with the matching data.
  - o_fill sequence is 0001,0011,0111,1111; o_count ends at 4.
  - o_full rises with the 4th o_wr; o_ready=0 thereafter.
- **Stall in FULL:** i_valid=1 held for 5 cycles with data 0x55 → no o_wr; o_count stays 4.
  - Then i_release for 1 cycle → o_count=0, o_fill=0 next cycle and o_ready=1.
  - 0x55 is then written to lane 0.
- **Gapped input:** i_valid pattern 1,0,0,1 → exactly 2 o_wr pulses to lanes 0 and 1; o_wlane and o_wdata hold during the gaps.
- **Abort:** after 2 accepts, assert i_release together with i_valid=1 (data 0x99) → o_ready=0 that cycle and no write of 0x99. Next cycle: count=0, ptr=0, state IDLE.
- **Wrap:** fill, release, then fill again → the second fill's first o_wlane=0 and the pattern matches the streaming-fill case.

Source files
------------

// File: rtl/lane_loader_pkg.sv
// Shared definitions for the lane loader and the open-lane memory bank.
// Both sides instantiate from these defaults so lane count and widths agree.
package lane_loader_pkg;

  // Default bank geometry
  localparam int LL_NLANES = 4;
  localparam int LL_LWIDTH = 2;
  localparam int LL_DWIDTH = 8;

  // Loader state encoding
  typedef enum logic [1:0] {
    LL_IDLE = 2'd0,
    LL_FILL = 2'd1,
    LL_FULL = 2'd2
  } ll_state_e;

endpackage

// File: rtl/lane_loader_lane_ptr.sv
// Wrapping lane pointer: increments on inc_i, returns to 0 after N-1,
// and clears on clr_i (clear has priority). Shared with the read side.
module lane_ptr #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] ptr_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Next pointer: clear wins, otherwise step with wrap at the last lane
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      if (ptr_q == LAST) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + W'(1);
      end
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/lane_loader.sv
// Upstream write sequencer for the open-lane bank. Accepts words on a
// valid/ready handshake and writes them to consecutive lanes, tracking
// which lanes hold fresh data until the consumer releases the bank.
//
// Handshake: a word transfers on a rising edge where i_valid && o_ready.
// The upstream must hold i_valid and i_data stable until that happens;
// o_ready is low in FULL, while i_release is high, and while rst is low.
module lane_loader
  import lane_loader_pkg::*;
#(
  parameter int NLANES = LL_NLANES,
  parameter int LWIDTH = LL_LWIDTH,
  parameter int DWIDTH = LL_DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [DWIDTH-1:0] i_data,
  output logic              o_ready,
  input  logic              i_release,
  output logic              o_wr,
  output logic [LWIDTH-1:0] o_wlane,
  output logic [DWIDTH-1:0] o_wdata,
  output logic [NLANES-1:0] o_fill,
  output logic [LWIDTH:0]   o_count,
  output logic              o_full,
  output ll_state_e         o_state
);

  localparam logic [LWIDTH:0] NL_C = (LWIDTH + 1)'(NLANES);

  ll_state_e         state_q, state_d;
  logic [LWIDTH:0]   count_q, count_d;
  logic [NLANES-1:0] fill_q,  fill_d;
  logic              wr_q,    wr_d;
  logic [LWIDTH-1:0] wlane_q, wlane_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic              full_q,  full_d;
  logic [LWIDTH-1:0] ptr;
  logic              accept;

  // Release has priority over an offered word, so it simply gates ready
  assign o_ready = rst && (state_q != LL_FULL) && !i_release;
  assign accept  = i_valid && o_ready;

  lane_ptr #(
    .N (NLANES),
    .W (LWIDTH)
  ) u_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (accept),
    .clr_i (i_release),
    .ptr_o (ptr)
  );

  // Next-state, fill mask and write-port values
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    fill_d  = fill_q;
    wr_d    = 1'b0;
    wlane_d = wlane_q;
    wdata_d = wdata_q;
    if (i_release) begin
      // Handoff from FULL, or abort from IDLE/FILL: written lanes keep
      // their bank contents but are reported empty.
      state_d = LL_IDLE;
      count_d = '0;
      fill_d  = '0;
    end else begin
      case (state_q)
        LL_IDLE, LL_FILL: begin
          if (accept) begin
            wr_d    = 1'b1;
            wlane_d = ptr;
            wdata_d = i_data;
            count_d = count_q + (LWIDTH + 1)'(1);
            for (int k = 0; k < NLANES; k++) begin
              if (ptr == LWIDTH'(k)) begin
                fill_d[k] = 1'b1;
              end
            end
            state_d = (count_d == NL_C) ? LL_FULL : LL_FILL;
          end
        end
        LL_FULL: begin
          state_d = LL_FULL;
        end
        default: begin
          state_d = LL_IDLE;
        end
      endcase
    end
    full_d = (count_d == NL_C);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LL_IDLE;
      count_q <= '0;
      fill_q  <= '0;
      wr_q    <= 1'b0;
      wlane_q <= '0;
      wdata_q <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      fill_q  <= fill_d;
      wr_q    <= wr_d;
      wlane_q <= wlane_d;
      wdata_q <= wdata_d;
      full_q  <= full_d;
    end
  end

  assign o_wr    = wr_q;
  assign o_wlane = wlane_q;
  assign o_wdata = wdata_q;
  assign o_fill  = fill_q;
  assign o_count = count_q;
  assign o_full  = full_q;
  assign o_state = state_q;

endmodule
